// File: rtl/i2c_codec_responder.sv
// Write-only I2C target for the codec control protocol: ACKs frames sent to
// DEV_ADDR, decodes the 16-bit word into {addr[6:0], data[8:0]} and stores
// it in a small register file.
module i2c_codec_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned NREG     = 16,
  parameter logic [6:0]  CLR_ADDR = 7'h0F
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [3:0] i_raddr,
  output logic [8:0] o_rdata,
  output logic       o_busy
);

  localparam int unsigned AW  = 7;
  localparam int unsigned DW  = 9;
  localparam int unsigned BW  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned RAW = 4;
  localparam int unsigned IW  = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_BYTE1,
    S_ACK1,
    S_BYTE2,
    S_ACK2,
    S_OVERRUN,
    S_IGNORE
  } state_t;

  state_t state_q, state_d;

  // [0] metastability flop, [1] synchronized value, [2] previous value
  logic [2:0] scl_pipe;
  logic [2:0] sda_pipe;

  logic scl_sync, scl_prev, sda_sync, sda_prev;
  logic scl_rise_c, scl_fall_c, start_c, stop_c;

  logic [BW-1:0] sr_q;
  logic [BW-1:0] b1_q;
  logic [CW-1:0] cnt_q;
  logic          byte_done_c;

  logic shift_c, cnt_clr_c, b1_load_c, commit_c;
  logic oe_d, busy_d;

  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [DW-1:0] regs [NREG];
  logic          rd_hit_c;

  // Bus input synchronizers, reset to the idle-high bus level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], i_scl};
      sda_pipe <= {sda_pipe[1:0], i_sda};
    end
  end

  assign scl_sync = scl_pipe[1];
  assign scl_prev = scl_pipe[2];
  assign sda_sync = sda_pipe[1];
  assign sda_prev = sda_pipe[2];

  // Bus events; SDA moving while SCL stays high is START/STOP, never data
  assign scl_rise_c = scl_sync & ~scl_prev;
  assign scl_fall_c = ~scl_sync & scl_prev;
  assign start_c    = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_c     = scl_sync & scl_prev & ~sda_prev & sda_sync;

  assign byte_done_c = (cnt_q == CW'(BW));

  // Frame state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    shift_c   = 1'b0;
    cnt_clr_c = 1'b0;
    b1_load_c = 1'b0;
    commit_c  = 1'b0;
    if (start_c) begin
      state_d   = S_ADDR;
      cnt_clr_c = 1'b1;
    end else if (stop_c) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise_c && !byte_done_c) begin
            shift_c = 1'b1;
          end else if (scl_fall_c && byte_done_c) begin
            if (sr_q[7:1] == DEV_ADDR && !sr_q[0]) state_d = S_ACK_A;
            else                                   state_d = S_IGNORE;
          end
        end
        S_ACK_A: begin
          if (scl_fall_c) begin
            state_d   = S_BYTE1;
            cnt_clr_c = 1'b1;
          end
        end
        S_BYTE1: begin
          if (scl_rise_c && !byte_done_c) begin
            shift_c = 1'b1;
          end else if (scl_fall_c && byte_done_c) begin
            state_d   = S_ACK1;
            b1_load_c = 1'b1;
          end
        end
        S_ACK1: begin
          if (scl_fall_c) begin
            state_d   = S_BYTE2;
            cnt_clr_c = 1'b1;
          end
        end
        S_BYTE2: begin
          if (scl_rise_c && !byte_done_c) begin
            shift_c = 1'b1;
          end else if (scl_fall_c && byte_done_c) begin
            state_d = S_ACK2;
          end
        end
        S_ACK2: begin
          if (scl_fall_c) begin
            state_d  = S_OVERRUN;
            commit_c = 1'b1;
          end
        end
        S_OVERRUN: ;
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
    oe_d   = (state_d == S_ACK_A) || (state_d == S_ACK1) || (state_d == S_ACK2);
    busy_d = (state_d != S_IDLE);
  end

  // Bit shifter, bit counter and first-byte latch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q  <= '0;
      b1_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (cnt_clr_c) begin
        cnt_q <= '0;
      end else if (shift_c) begin
        sr_q  <= {sr_q[BW-2:0], sda_sync};
        cnt_q <= cnt_q + CW'(1);
      end
      if (b1_load_c) b1_q <= sr_q;
    end
  end

  assign wr_addr_c = b1_q[7:1];
  assign wr_data_c = {b1_q[0], sr_q};

  // Registered bus/status outputs and commit strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sda_oe   <= 1'b0;
      o_busy     <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
    end else begin
      o_sda_oe   <= oe_d;
      o_busy     <= busy_d;
      o_wr_valid <= commit_c;
      if (commit_c) begin
        o_wr_addr <= wr_addr_c;
        o_wr_data <= wr_data_c;
      end
    end
  end

  // Register file: clear-all on CLR_ADDR, out-of-range addresses are dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[IW'(i)] <= '0;
    end else if (commit_c) begin
      if (wr_addr_c == CLR_ADDR) begin
        for (int unsigned i = 0; i < NREG; i++) regs[IW'(i)] <= '0;
      end else if (32'(wr_addr_c) < NREG) begin
        regs[IW'(wr_addr_c)] <= wr_data_c;
      end
    end
  end

  // Read addresses beyond the file return zero when the file is shallow
  if (NREG >= (1 << RAW)) begin : g_rd_full
    assign rd_hit_c = 1'b1;
  end else begin : g_rd_part
    assign rd_hit_c = (32'(i_raddr) < NREG);
  end

  // Registered read port; sees the pre-commit value in the commit cycle
  always_ff @(posedge i_clk) begin
    if (i_rst)         o_rdata <= '0;
    else if (rd_hit_c) o_rdata <= regs[IW'(i_raddr)];
    else               o_rdata <= '0;
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: bit-bangs I2C frames as the bus
// controller and checks ACKs, write strobes and register-file contents.
module tb_i2c_codec_responder;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_w;
  logic       o_sda_oe, o_wr_valid, o_busy;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data, o_rdata;
  logic [3:0] i_raddr = 4'd0;

  int tot = 0;
  int bad = 0;

  // Bus monitor counters, written only by the monitor process
  int       strobe_cnt = 0;
  int       oe_cnt = 0;
  logic     prev_valid = 1'b0;
  logic [8:0] rd_at_commit = '0;
  logic [8:0] rd_after = '0;

  // Open-drain SDA wire
  assign sda_w = sda_m & ~o_sda_oe;

  always #5 i_clk = ~i_clk;

  i2c_codec_responder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_scl(scl_m), .i_sda(sda_w),
    .o_sda_oe(o_sda_oe), .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .i_raddr(i_raddr), .o_rdata(o_rdata), .o_busy(o_busy)
  );

  // Count strobes/ACK-drive cycles and capture read data around each commit
  always @(negedge i_clk) begin
    if (o_wr_valid === 1'b1) begin
      strobe_cnt++;
      rd_at_commit = o_rdata;
    end
    if (prev_valid) rd_after = o_rdata;
    prev_valid = (o_wr_valid === 1'b1);
    if (o_sda_oe === 1'b1) oe_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic bus_start();
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(8); sda_m = 1'b0;
    wait_clk(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(4); sda_m = 1'b0;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(8); sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(4); sda_m = b;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(8); scl_m = 1'b0;
  endtask

  task automatic get_ack(output logic a);
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(4); a = o_sda_oe;
    wait_clk(4); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(a);
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [8:0] v);
    i_raddr = a;
    wait_clk(2);
    v = o_rdata;
  endtask

  task automatic test_reset();
    logic [8:0] v;
    i_rst = 1'b1; wait_clk(3); i_rst = 1'b0; wait_clk(2);
    tot++; if (o_sda_oe !== 1'b0)  begin bad++; $display("FAIL reset_oe got=%b want=0", o_sda_oe); end
    tot++; if (o_wr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_wr_valid); end
    tot++; if (o_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    tot++; if (o_wr_addr !== 7'h00) begin bad++; $display("FAIL reset_wr_addr got=%h want=00", o_wr_addr); end
    tot++; if (o_wr_data !== 9'h000) begin bad++; $display("FAIL reset_wr_data got=%h want=000", o_wr_data); end
    read_reg(4'd4, v);
    tot++; if (v !== 9'h000) begin bad++; $display("FAIL reset_reg4 got=%h want=000", v); end
  endtask

  task automatic test_single_write();
    logic a0, a1, a2;
    logic [8:0] v;
    int s0 = strobe_cnt;
    bus_start();
    wait_clk(2);
    tot++; if (o_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", o_busy); end
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h12, a2);
    bus_stop();
    tot++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL single_acks got=%b want=111", {a0, a1, a2}); end
    tot++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL single_strobes got=%0d want=1", strobe_cnt - s0); end
    tot++; if (o_wr_addr !== 7'h04) begin bad++; $display("FAIL single_addr got=%h want=04", o_wr_addr); end
    tot++; if (o_wr_data !== 9'h012) begin bad++; $display("FAIL single_data got=%h want=012", o_wr_data); end
    tot++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", o_busy); end
    read_reg(4'd4, v);
    tot++; if (v !== 9'h012) begin bad++; $display("FAIL single_reg4 got=%h want=012", v); end
    read_reg(4'd5, v);
    tot++; if (v !== 9'h000) begin bad++; $display("FAIL single_reg5 got=%h want=000", v); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, a2;
    logic [8:0] v;
    logic [7:0] abyte [2];
    abyte[0] = 8'h36; abyte[1] = 8'h35;
    for (int k = 0; k < 2; k++) begin
      int s0 = strobe_cnt;
      int o0 = oe_cnt;
      bus_start();
      send_byte(abyte[k], a0); send_byte(8'h0A, a1); send_byte(8'h77, a2);
      bus_stop();
      tot++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL wrong_addr_oe byte=%h got=%0d want=0", abyte[k], oe_cnt - o0); end
      tot++; if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL wrong_addr_strobe byte=%h got=%0d want=0", abyte[k], strobe_cnt - s0); end
      read_reg(4'd5, v);
      tot++; if (v !== 9'h000) begin bad++; $display("FAIL wrong_addr_reg5 byte=%h got=%h want=000", abyte[k], v); end
    end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [8:0] v;
    int s0 = strobe_cnt;
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h08, a1);
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h0F, a1); send_byte(8'hFF, a2);
    bus_stop();
    tot++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL rstart_acks got=%b want=111", {a0, a1, a2}); end
    tot++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL rstart_strobes got=%0d want=1", strobe_cnt - s0); end
    tot++; if (o_wr_addr !== 7'h07) begin bad++; $display("FAIL rstart_addr got=%h want=07", o_wr_addr); end
    tot++; if (o_wr_data !== 9'h1FF) begin bad++; $display("FAIL rstart_data got=%h want=1ff", o_wr_data); end
    read_reg(4'd7, v);
    tot++; if (v !== 9'h1FF) begin bad++; $display("FAIL rstart_reg7 got=%h want=1ff", v); end
    read_reg(4'd4, v);
    tot++; if (v !== 9'h012) begin bad++; $display("FAIL rstart_reg4 got=%h want=012", v); end
  endtask

  task automatic test_stop_abort();
    logic a0, a1;
    logic [8:0] v;
    int s0 = strobe_cnt;
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h0A, a1);
    bus_stop();
    tot++; if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL abort_strobes got=%0d want=0", strobe_cnt - s0); end
    tot++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", o_busy); end
    read_reg(4'd5, v);
    tot++; if (v !== 9'h000) begin bad++; $display("FAIL abort_reg5 got=%h want=000", v); end
  endtask

  task automatic test_clear_oor();
    logic a0, a1, a2;
    logic [8:0] v;
    int s0 = strobe_cnt;
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h40, a1); send_byte(8'h55, a2);
    bus_stop();
    tot++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL oor_acks got=%b want=111", {a0, a1, a2}); end
    tot++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL oor_strobes got=%0d want=1", strobe_cnt - s0); end
    tot++; if (o_wr_addr !== 7'h20) begin bad++; $display("FAIL oor_addr got=%h want=20", o_wr_addr); end
    tot++; if (o_wr_data !== 9'h055) begin bad++; $display("FAIL oor_data got=%h want=055", o_wr_data); end
    read_reg(4'd4, v);
    tot++; if (v !== 9'h012) begin bad++; $display("FAIL oor_reg4 got=%h want=012", v); end
    read_reg(4'd7, v);
    tot++; if (v !== 9'h1FF) begin bad++; $display("FAIL oor_reg7 got=%h want=1ff", v); end
    s0 = strobe_cnt;
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    bus_stop();
    tot++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL clr_strobes got=%0d want=1", strobe_cnt - s0); end
    tot++; if (o_wr_addr !== 7'h0F) begin bad++; $display("FAIL clr_addr got=%h want=0f", o_wr_addr); end
    for (int r = 0; r < 16; r++) begin
      read_reg(4'(r), v);
      tot++; if (v !== 9'h000) begin bad++; $display("FAIL clr_reg%0d got=%h want=000", r, v); end
    end
  endtask

  task automatic test_overrun();
    logic a0, a1, a2, a3;
    logic [8:0] v;
    int s0 = strobe_cnt;
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h12, a2); send_byte(8'h55, a3);
    bus_stop();
    tot++; if ({a0, a1, a2, a3} !== 4'b1110) begin bad++; $display("FAIL overrun_acks got=%b want=1110", {a0, a1, a2, a3}); end
    tot++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL overrun_strobes got=%0d want=1", strobe_cnt - s0); end
    tot++; if (o_wr_data !== 9'h012) begin bad++; $display("FAIL overrun_data got=%h want=012", o_wr_data); end
    read_reg(4'd4, v);
    tot++; if (v !== 9'h012) begin bad++; $display("FAIL overrun_reg4 got=%h want=012", v); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [8:0] v;
    int s0 = strobe_cnt;
    i_raddr = 4'd4;
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'hAB, a2);
    bus_stop();
    tot++; if (rd_at_commit !== 9'h012) begin bad++; $display("FAIL b2b_rd_commit got=%h want=012", rd_at_commit); end
    tot++; if (rd_after !== 9'h0AB) begin bad++; $display("FAIL b2b_rd_after got=%h want=0ab", rd_after); end
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h03, a1); send_byte(8'h00, a2);
    bus_stop();
    tot++; if (strobe_cnt - s0 !== 2) begin bad++; $display("FAIL b2b_strobes got=%0d want=2", strobe_cnt - s0); end
    read_reg(4'd1, v);
    tot++; if (v !== 9'h100) begin bad++; $display("FAIL b2b_reg1 got=%h want=100", v); end
    read_reg(4'd4, v);
    tot++; if (v !== 9'h0AB) begin bad++; $display("FAIL b2b_reg4 got=%h want=0ab", v); end
  endtask

  task automatic test_reset_midframe();
    logic a0, a1, a2;
    logic [8:0] v;
    int s0 = strobe_cnt;
    bus_start();
    send_byte(8'h34, a0); send_byte(8'h08, a1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    i_rst = 1'b1;
    wait_clk(1);
    i_rst = 1'b0;
    tot++; if (o_sda_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe got=%b want=0", o_sda_oe); end
    tot++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", o_busy); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    get_ack(a2);
    tot++; if (a2 !== 1'b0) begin bad++; $display("FAIL rstmid_ack got=%b want=0", a2); end
    tot++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_later got=%b want=0", o_busy); end
    bus_stop();
    tot++; if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL rstmid_strobes got=%0d want=0", strobe_cnt - s0); end
    read_reg(4'd4, v);
    tot++; if (v !== 9'h000) begin bad++; $display("FAIL rstmid_reg4 got=%h want=000", v); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wrong_addr();
    test_repeated_start();
    test_stop_abort();
    test_clear_oor();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
